// File: rtl/bcd_down_counter_if.sv
// Control and status bundle for the BCD down counter.
// master drives load/en/load_val; slave (the counter) drives the count and flags.
interface bcd_down_counter_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic [4*DIGITS-1:0]   q;
  logic [4*DIGITS-1:0]   qbar;
  logic                  zero;
  logic                  tc;
  logic                  err;

  modport master (
    output load, load_val, en,
    input  q, qbar, zero, tc, err
  );

  modport slave (
    input  load, load_val, en,
    output q, qbar, zero, tc, err
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Synchronous multi-digit BCD down counter with parallel load,
// registered terminal-count and invalid-load pulses.
module bcd_down_counter #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_down_counter_if.slave   bus
);
  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         err_q, err_d;

  logic         load_ok;
  logic [W-1:0] dec_val;
  logic         borrow;
  logic         q_is_zero;

  // Load-value check and one-step decrement with a ripple borrow across digits.
  // At zero every digit borrows, so dec_val is all 9s, which is the wrap value.
  always_comb begin
    load_ok = 1'b1;
    dec_val = '0;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
      if (!borrow) begin
        dec_val[4*i +: 4] = q_q[4*i +: 4];
      end else if (q_q[4*i +: 4] == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
      end else begin
        dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
        borrow            = 1'b0;
      end
    end
  end

  assign q_is_zero = (q_q == '0);

  // Next count and pulse flags with load > en > hold priority.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        q_d = bus.load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (q_is_zero) begin
        q_d = WRAP ? dec_val : q_q;
      end else begin
        q_d  = dec_val;
        tc_d = (dec_val == '0);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.zero = q_is_zero;
  assign bus.tc   = tc_q;
  assign bus.err  = err_q;
endmodule
